matmul_sp_reader: RTL and testbench



---
 rtl/matmul_pkg.sv | 34 +++
 rtl/matmul_apb_rd_master.sv | 50 +++++
 rtl/matmul_sp_reader.sv | 174 +++++++++++++++++
 tb/tb_matmul_sp_reader.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// ============================================================================
// Module      : matmul_pkg
// Description : Shared sizes, APB register codes and reader FSM states for
//               the matmul accelerator readback path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package matmul_pkg;

    localparam int BUS_WIDTH   = 16;
    localparam int ADDR_WIDTH  = 16;
    localparam int MAX_DIM     = 4;
    localparam int SP_NTARGETS = 4;

    // Low five address bits select the register block
    localparam logic [4:0] c_reg_control   = 5'b00000;
    localparam logic [4:0] c_reg_operand_a = 5'b00100;
    localparam logic [4:0] c_reg_operand_b = 5'b01000;
    localparam logic [4:0] c_reg_flags     = 5'b01100;
    localparam logic [4:0] c_reg_sp        = 5'b10000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_ACCESS  = 3'd2,
        ST_FSETUP  = 3'd3,
        ST_FACCESS = 3'd4,
        ST_DONE    = 3'd5
    } sp_reader_state_t;

endpackage

`default_nettype wire

// File: rtl/matmul_apb_rd_master.sv
// ============================================================================
// Module      : matmul_apb_rd_master
// Description : One APB read transaction: drives psel/penable from the
//               caller's phase, counts wait states and flags a timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module matmul_apb_rd_master
    import matmul_pkg::*;
#(
    parameter int BUS_WIDTH = matmul_pkg::BUS_WIDTH,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 setup_i,
    input  logic                 access_i,
    input  logic                 pready_i,
    input  logic [BUS_WIDTH-1:0] prdata_i,
    output logic                 psel_o,
    output logic                 penable_o,
    output logic                 valid_o,
    output logic                 timeout_o,
    output logic [BUS_WIDTH-1:0] rdata_o
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    logic [WAIT_W-1:0] r_wait;

    // Every access phase is preceded by a setup phase, so holding the
    // counter at zero outside ACCESS restarts it for each transfer.
    always_ff @(posedge clk_i) begin
        if (rst_i || !access_i) begin
            r_wait <= '0;
        end else if (!pready_i) begin
            r_wait <= r_wait + WAIT_W'(1);
        end
    end

    assign psel_o    = setup_i | access_i;
    assign penable_o = access_i;
    assign valid_o   = access_i & pready_i;
    assign timeout_o = access_i & ~pready_i & (r_wait == WAIT_W'(TIMEOUT - 1));
    assign rdata_o   = prdata_i;

endmodule

`default_nettype wire

// File: rtl/matmul_sp_reader.sv
// ============================================================================
// Module      : matmul_sp_reader
// Description : Drains result matrix C and FLAGS over APB after a run and
//               presents them as flattened buses for the golden checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module matmul_sp_reader
    import matmul_pkg::*;
#(
    parameter int BUS_WIDTH   = matmul_pkg::BUS_WIDTH,
    parameter int ADDR_WIDTH  = matmul_pkg::ADDR_WIDTH,
    parameter int MAX_DIM     = matmul_pkg::MAX_DIM,
    parameter int SP_NTARGETS = matmul_pkg::SP_NTARGETS,
    parameter int TIMEOUT     = 255
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   start_i,
    input  logic [7:0]                             rows_i,
    input  logic [7:0]                             cols_i,
    input  logic [$clog2(SP_NTARGETS)-1:0]         sp_sel_i,
    output logic                                   psel_o,
    output logic                                   penable_o,
    output logic                                   pwrite_o,
    output logic [ADDR_WIDTH-1:0]                  paddr_o,
    input  logic [BUS_WIDTH-1:0]                   prdata_i,
    input  logic                                   pready_i,
    output logic                                   busy_o,
    output logic                                   done_o,
    output logic                                   timeout_o,
    output logic [BUS_WIDTH*MAX_DIM*MAX_DIM-1:0]   data_sp_o,
    output logic [BUS_WIDTH-1:0]                   flags_o
);

    localparam int SEL_W  = $clog2(SP_NTARGETS);
    localparam int CNT_W  = $clog2(MAX_DIM + 1);
    localparam int IDX_W  = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
    localparam int ELEM_W = (MAX_DIM > 1) ? $clog2(MAX_DIM * MAX_DIM) : 1;
    localparam int UP_W   = ADDR_WIDTH - 5;

    sp_reader_state_t r_state, w_next;

    logic [CNT_W-1:0]     r_rows, r_cols, w_rows_clamped, w_cols_clamped;
    logic [SEL_W-1:0]     r_sp_sel;
    logic [IDX_W-1:0]     r_i, r_j;
    logic [ELEM_W-1:0]    w_elem;
    logic                 w_accept, w_last_col, w_last_elem;
    logic                 w_setup, w_access, w_valid, w_timeout;
    logic [BUS_WIDTH-1:0] w_rdata;
    logic [BUS_WIDTH*MAX_DIM*MAX_DIM-1:0] r_data;
    logic [BUS_WIDTH-1:0] r_flags;
    logic                 r_done, r_timeout;

    assign w_rows_clamped = (rows_i > 8'(MAX_DIM)) ? CNT_W'(MAX_DIM) : rows_i[CNT_W-1:0];
    assign w_cols_clamped = (cols_i > 8'(MAX_DIM)) ? CNT_W'(MAX_DIM) : cols_i[CNT_W-1:0];

    assign w_accept    = start_i & ((r_state == ST_IDLE) | (r_state == ST_DONE));
    assign w_last_col  = (CNT_W'(r_j) == r_cols - CNT_W'(1));
    assign w_last_elem = w_last_col & (CNT_W'(r_i) == r_rows - CNT_W'(1));
    assign w_elem      = ELEM_W'(r_i) * ELEM_W'(MAX_DIM) + ELEM_W'(r_j);
    assign w_setup     = (r_state == ST_SETUP)  | (r_state == ST_FSETUP);
    assign w_access    = (r_state == ST_ACCESS) | (r_state == ST_FACCESS);

    matmul_apb_rd_master #(
        .BUS_WIDTH (BUS_WIDTH),
        .TIMEOUT   (TIMEOUT)
    ) u_apb_rd (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .setup_i   (w_setup),
        .access_i  (w_access),
        .pready_i  (pready_i),
        .prdata_i  (prdata_i),
        .psel_o    (psel_o),
        .penable_o (penable_o),
        .valid_o   (w_valid),
        .timeout_o (w_timeout),
        .rdata_o   (w_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    w_next = ((w_rows_clamped == '0) || (w_cols_clamped == '0)) ? ST_FSETUP : ST_SETUP;
                end
            end
            ST_SETUP:  w_next = ST_ACCESS;
            ST_ACCESS: begin
                if (w_timeout) begin
                    w_next = ST_DONE;
                end else if (w_valid) begin
                    w_next = w_last_elem ? ST_FSETUP : ST_SETUP;
                end
            end
            ST_FSETUP:  w_next = ST_FACCESS;
            ST_FACCESS: begin
                if (w_timeout || w_valid) begin
                    w_next = ST_DONE;
                end
            end
            default:    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rows    <= '0;
            r_cols    <= '0;
            r_sp_sel  <= '0;
            r_i       <= '0;
            r_j       <= '0;
            r_data    <= '0;
            r_flags   <= '0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
        end else if (w_accept) begin
            r_rows    <= w_rows_clamped;
            r_cols    <= w_cols_clamped;
            r_sp_sel  <= sp_sel_i;
            r_i       <= '0;
            r_j       <= '0;
            r_data    <= '0;
            r_flags   <= '0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
        end else if (w_timeout) begin
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
        end else if ((r_state == ST_ACCESS) && w_valid) begin
            r_data[int'(w_elem) * BUS_WIDTH +: BUS_WIDTH] <= w_rdata;
            if (w_last_col) begin
                r_j <= '0;
                r_i <= r_i + IDX_W'(1);
            end else begin
                r_j <= r_j + IDX_W'(1);
            end
        end else if ((r_state == ST_FACCESS) && w_valid) begin
            r_flags <= w_rdata;
            r_done  <= 1'b1;
        end
    end

    // Address is forced to zero outside a transfer so idle bus is quiet
    always_comb begin
        paddr_o = '0;
        if ((r_state == ST_SETUP) || (r_state == ST_ACCESS)) begin
            paddr_o = {UP_W'(r_sp_sel) * UP_W'(MAX_DIM * MAX_DIM) + UP_W'(w_elem), c_reg_sp};
        end else if ((r_state == ST_FSETUP) || (r_state == ST_FACCESS)) begin
            paddr_o = {{UP_W{1'b0}}, c_reg_flags};
        end
    end

    assign pwrite_o  = 1'b0;
    assign busy_o    = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign done_o    = r_done;
    assign timeout_o = r_timeout;
    assign data_sp_o = r_data;
    assign flags_o   = r_flags;

endmodule

`default_nettype wire

// File: tb/tb_matmul_sp_reader.sv
// ============================================================================
// Module      : tb_matmul_sp_reader
// Description : Randomized scoreboard bench for matmul_sp_reader with an
//               APB slave model and a matrix-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_matmul_sp_reader;

    localparam int BW  = 16;
    localparam int AW  = 16;
    localparam int MD  = 4;
    localparam int NSP = 4;
    localparam int TMO = 255;
    localparam int DW  = BW * MD * MD;

    logic          clk = 1'b0;
    logic          rst_i, start_i, pready_i;
    logic [7:0]    rows_i, cols_i;
    logic [1:0]    sp_sel_i;
    logic          psel_o, penable_o, pwrite_o, busy_o, done_o, timeout_o;
    logic [AW-1:0] paddr_o;
    logic [BW-1:0] prdata_i, flags_o;
    logic [DW-1:0] data_sp_o;

    always #5 clk = ~clk;

    matmul_sp_reader #(
        .BUS_WIDTH(BW), .ADDR_WIDTH(AW), .MAX_DIM(MD), .SP_NTARGETS(NSP), .TIMEOUT(TMO)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .rows_i(rows_i), .cols_i(cols_i),
        .sp_sel_i(sp_sel_i), .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
        .paddr_o(paddr_o), .prdata_i(prdata_i), .pready_i(pready_i), .busy_o(busy_o),
        .done_o(done_o), .timeout_o(timeout_o), .data_sp_o(data_sp_o), .flags_o(flags_o)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [BW-1:0] flags;
        logic          tmo;
        int            lat;
        int            nacc;
        int            acc_cyc;
    } exp_t;

    exp_t          exp_q[$];
    logic [AW-1:0] addr_q[$];
    exp_t          mon_e;

    int n_cmp = 0, n_err = 0, cyc = 0;
    int cfg_waits = 0, cfg_stall_idx = 0, acc_cnt = 0, wait_cnt = 0;
    bit cfg_stall = 0;
    logic [BW-1:0] cfg_salt = '0, cfg_flags = '0;
    logic [AW-1:0] setup_addr = '0;
    logic [AW-1:0] exp_addr;
    logic          done_q = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " psel"},    DW'(psel_o),    '0);
        chk({tag, " penable"}, DW'(penable_o), '0);
        chk({tag, " pwrite"},  DW'(pwrite_o),  '0);
        chk({tag, " paddr"},   DW'(paddr_o),   '0);
        chk({tag, " busy"},    DW'(busy_o),    '0);
        chk({tag, " done"},    DW'(done_o),    '0);
        chk({tag, " timeout"}, DW'(timeout_o), '0);
        chk({tag, " data"},    data_sp_o,      '0);
        chk({tag, " flags"},   DW'(flags_o),   '0);
    endtask

    // APB slave: programmable wait states, optional permanent stall, and
    // junk on pready/prdata outside the access phase.
    always @(negedge clk) begin
        if (psel_o && !penable_o) setup_addr = paddr_o;
        if (psel_o && penable_o) begin
            if ((cfg_stall && acc_cnt == cfg_stall_idx) || wait_cnt < cfg_waits) begin
                pready_i = 1'b0;
                prdata_i = BW'($urandom);
                wait_cnt++;
            end else begin
                pready_i = 1'b1;
                if (addr_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected access: paddr %0h", paddr_o);
                end else begin
                    exp_addr = addr_q.pop_front();
                    chk("paddr", DW'(paddr_o), DW'(exp_addr));
                end
                chk("paddr stable", DW'(paddr_o), DW'(setup_addr));
                chk("pwrite", DW'(pwrite_o), '0);
                prdata_i = (paddr_o[4:0] == 5'b01100) ? cfg_flags : ({5'b0, paddr_o[15:5]} ^ cfg_salt);
                acc_cnt++;
                wait_cnt = 0;
            end
        end else begin
            pready_i = 1'($urandom);
            prdata_i = BW'($urandom);
            wait_cnt = 0;
        end
    end

    // Result monitor: on each rising done_o, compare against the oldest expectation
    always @(negedge clk) begin
        if (done_o && !done_q) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected done: cycle %0d", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("data_sp", data_sp_o, mon_e.data);
                chk("flags", DW'(flags_o), DW'(mon_e.flags));
                chk("timeout", DW'(timeout_o), DW'(mon_e.tmo));
                chk("latency", DW'(cyc - mon_e.acc_cyc), DW'(mon_e.lat));
                chk("access count", DW'(acc_cnt), DW'(mon_e.nacc));
                chk("busy at done", DW'(busy_o), '0);
            end
        end
        done_q = done_o;
    end

    task automatic run_txn(input int rows, input int cols, input int sp, input int waits,
                           input logic [BW-1:0] salt, input bit stall, input int sidx,
                           input bit poke, input int rst_at);
        exp_t e;
        logic [DW-1:0] d;
        int r, c, nacc, idx;
        r = (rows > MD) ? MD : rows;
        c = (cols > MD) ? MD : cols;
        cfg_waits = waits; cfg_salt = salt; cfg_flags = BW'($urandom);
        cfg_stall = stall; cfg_stall_idx = sidx; acc_cnt = 0;
        d = '0; nacc = 0;
        for (int i = 0; i < r; i++) begin
            for (int j = 0; j < c; j++) begin
                if (!stall || nacc < sidx) begin
                    idx = sp * MD * MD + i * MD + j;
                    d[(i * MD + j) * BW +: BW] = idx[BW-1:0] ^ salt;
                    addr_q.push_back({idx[AW-6:0], 5'b10000});
                    nacc++;
                end
            end
        end
        e.data = d;
        if (!stall) begin
            addr_q.push_back(16'h000C);
            nacc++;
            e.flags = cfg_flags; e.tmo = 1'b0; e.lat = nacc * (2 + waits);
        end else begin
            e.flags = '0; e.tmo = 1'b1; e.lat = sidx * (2 + waits) + 1 + TMO;
        end
        e.nacc = nacc;

        @(posedge clk); #1;
        rows_i = 8'(rows); cols_i = 8'(cols); sp_sel_i = 2'(sp); start_i = 1'b1;
        e.acc_cyc = cyc + 1;
        exp_q.push_back(e);
        @(posedge clk); #1;
        start_i = 1'b0; rows_i = 8'($urandom); cols_i = 8'($urandom); sp_sel_i = 2'($urandom);
        chk("accept clears done", DW'(done_o), '0);
        chk("accept clears timeout", DW'(timeout_o), '0);
        chk("accept clears data", data_sp_o, '0);
        chk("accept clears flags", DW'(flags_o), '0);
        chk("busy after accept", DW'(busy_o), DW'(1));
        chk("psel after accept", DW'(psel_o), DW'(1));
        chk("penable after accept", DW'(penable_o), '0);

        for (int k = 0; k < 3000 && !done_o; k++) begin
            if (rst_at >= 0 && acc_cnt == rst_at) begin
                rst_i = 1'b1;
                @(posedge clk); #1;
                chk_zero("mid-transfer reset");
                rst_i = 1'b0;
                exp_q.delete();
                addr_q.delete();
                return;
            end
            if (poke && k == 4) begin
                start_i = 1'b1; rows_i = 8'd1; cols_i = 8'd1;
            end else begin
                start_i = 1'b0;
            end
            @(posedge clk); #1;
        end
        start_i = 1'b0;
        chk("done within budget", DW'(done_o), DW'(1));
        repeat (3) @(posedge clk);
        #1;
        chk("done held", DW'(done_o), DW'(1));
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; rows_i = '0; cols_i = '0; sp_sel_i = '0;
        pready_i = 1'b0; prdata_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_i = 1'b0;

        run_txn(4, 4, 1, 0, '0,             0, 0, 0, -1);
        run_txn(2, 3, 2, 3, BW'($urandom), 0, 0, 0, -1);
        run_txn(4, 4, 2, 0, BW'($urandom), 1, 2, 0, -1);
        run_txn(0, 3, 3, 0, BW'($urandom), 0, 0, 0, -1);
        run_txn(9, 9, 3, 1, BW'($urandom), 0, 0, 0, -1);
        run_txn(4, 4, 0, 1, BW'($urandom), 0, 0, 0, 5);
        run_txn(3, 3, 2, 2, BW'($urandom), 0, 0, 1, -1);
        for (int t = 0; t < 12; t++) begin
            run_txn($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 3),
                    $urandom_range(0, 3), BW'($urandom), 0, 0, 0, -1);
        end

        repeat (4) @(posedge clk);
        #1;
        chk("results pending", DW'(exp_q.size()), '0);
        chk("addresses pending", DW'(addr_q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
